cpu_dump_unit: RTL and testbench
================================

# cpu_dump_unit

Synthesizable end-of-run monitor for the single-cycle CPU. It watches the program counter, decides when the program has finished (explicit request, cycle budget exhausted, or PC stuck), and freezes the CPU through `halted_o`. It then streams register-file and data-memory contents over a valid/ready port. This replaces per-cycle printing with one parametrised, ordered snapshot. It sits beside the CPU top: it reads `pc_out_o` and owns spare combinational read ports on the register file and data memory.

## Interface
- `DATA_W`, 32, width of register and memory words
- `PC_W`, 32, program counter width
- `NUM_REGS`, 32, register-file entries dumped (≥1)
- `MEM_WORDS`, 32, data-memory words dumped (≥1)
- `MAX_CYCLES`, 560, cycle budget before forced halt (≥1)
- `STALL_LIMIT`, 4, consecutive cycles with unchanged PC that count as halt; 0 disables stall detection
- Derived widths: `CNT_W = $clog2(MAX_CYCLES+1)`; `IDX_W = $clog2(max(NUM_REGS,MEM_WORDS))`, minimum 1
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: asynchronous, active-low reset (the CPU `Start` net)
- `pc_i` in PC_W: current PC
- `dump_req_i` in 1: manual halt request, level-sampled
- `rf_addr_o` out IDX_W: register-file read address
- `rf_data_i` in DATA_W: register-file read data, combinational from `rf_addr_o`
- `dm_addr_o` out IDX_W: data-memory word index
- `dm_data_i` in DATA_W: data-memory read data, combinational
- `dump_valid_o` out 1, `dump_ready_i` in 1: output handshake
- `dump_sel_o` out 1: 0 = register, 1 = memory
- `dump_idx_o` out IDX_W: entry index
- `dump_data_o` out DATA_W: entry value
- `dump_last_o` out 1: final beat
- `halted_o` out 1: CPU must stop PC and all writes while high
- `done_o` out 1: dump complete
- `cause_o` out 2: halt cause
- `cycle_cnt_o` out CNT_W: cycles executed

## Operation
- FSM states, in order: RUN → SCAN_RF → SCAN_DM → DONE.
- Halt triggers are evaluated only in RUN.
- RUN:
  - `cycle_cnt_o` increments each cycle.
  - The stall counter increments when `pc_i == pc_prev` and clears when they differ; `pc_prev` updates every cycle.
  - Trigger on any of: `dump_req_i`; `cycle_cnt_o == MAX_CYCLES-1`; stall counter `== STALL_LIMIT-1` (only when STALL_LIMIT≠0).
  - On trigger, register the cause, set `halted_o`, and go to SCAN_RF.
  - Priority for simultaneous triggers: REQ > LIMIT > STALL.
- SCAN_RF / SCAN_DM:
  - Index counter `idx` drives `rf_addr_o` / `dm_addr_o`. The address output not in use holds 0.
  - Load condition: `!dump_valid_o || dump_ready_i`. When it holds, capture data[idx], sel, and idx into the output register, set valid, and increment idx.
  - After `idx == NUM_REGS-1` is loaded, go to SCAN_DM with idx = 0.
  - The beat loaded from `MEM_WORDS-1` has `dump_last_o = 1`.
- DONE is entered when the last beat is accepted (valid & ready). Then `dump_valid_o` = 0 and `done_o` = 1.
- DONE is terminal; only reset leaves it. `halted_o`, `cause_o`, and `cycle_cnt_o` stay frozen after the halt.
- `cycle_cnt_o` saturates and never wraps.

## Timing
- Reset values: all outputs 0; state RUN; `pc_prev`, stall counter, `idx` all 0.
- The trigger is seen in cycle t. `halted_o` is 1 from t+1.
- The first beat is valid at t+2 (entering SCAN_RF at t+1 loads the output register at the t+1 edge).
- With `dump_ready_i` held high: one beat per cycle, NUM_REGS+MEM_WORDS beats in total. `done_o` rises the cycle after the last handshake.
- Ready low: data, sel, idx, and last hold stable; valid stays high; idx does not advance.
- Ready toggling mid-stream: no beat is lost or duplicated.
- Reset asserted mid-scan: immediate return to reset values. The CPU restarts with `halted_o` = 0.
- `dump_req_i` while not in RUN: ignored.

## Structure
- Package `cpu_dump_pkg` holds:
  - State enum: RUN=2'd0, SCAN_RF=2'd1, SCAN_DM=2'd2, DONE=2'd3.
  - Cause constants: CAUSE_NONE=2'd0, CAUSE_REQ=2'd1, CAUSE_LIMIT=2'd2, CAUSE_STALL=2'd3.
- Sub-module `halt_detector` contains the cycle counter, stall counter, and trigger/cause priority logic.
- The top contains the FSM, index counter, and output register.

## Test plan
- Stuck PC: pc_i counts 0,4,8,12, then holds 12; STALL_LIMIT=4. Expected: trigger in the 4th cycle of PC=12, cause 3, `halted_o` the next cycle.
- Cycle budget: MAX_CYCLES=10 with the PC always changing. Expected: `halted_o` after cycle_cnt reaches 9, cause 2, `cycle_cnt_o` frozen at 9.
- Simultaneous triggers: `dump_req_i` asserted in the same cycle as the limit. Expected: cause 1.
- Full stream with ready always high: register k = k*3, memory k = 100+k. Expected: 64 beats in order (sel 0 idx 0..31, then sel 1 idx 0..31), last only on mem idx 31, `done_o` after it.
- Backpressure: ready alternates 1,0 and is held 0 for 5 cycles at beat 10. Expected: beat 10 holds stable, no loss or duplication, 64 beats total.
- Reset mid-scan at beat 20. Expected: all outputs 0, state RUN, `cycle_cnt_o` restarts from 0.

Source files
------------

// File: rtl/cpu_dump_pkg.sv
// Shared state encoding, halt-cause codes and width helper for the CPU end-of-run dump unit.
package cpu_dump_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SCAN_RF = 2'd1,
    SCAN_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_REQ   = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_STALL = 2'd3;

  // Index width that never collapses to zero bits for single-entry tables.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_dump_unit_halt_detector.sv
// Cycle budget, stuck-PC detection and prioritised halt trigger; counters only advance while running.
module halt_detector
  import cpu_dump_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int MAX_CYCLES  = 560,
  parameter int STALL_LIMIT = 4,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PC_W-1:0]  pc,
  input  logic             dump_req,
  output logic             trigger,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int SC_W = clog2_min1(STALL_LIMIT + 1);

  logic [PC_W-1:0] pc_prev;
  logic [SC_W-1:0] stall_cnt;
  logic [SC_W-1:0] stall_nxt;
  logic            limit_hit;
  logic            stall_hit;

  // stall_nxt already includes this cycle's comparison, so the trigger fires on the
  // STALL_LIMIT-th consecutive cycle spent at one PC value.
  always_comb begin
    stall_nxt = '0;
    if (pc == pc_prev) begin
      stall_nxt = (stall_cnt == SC_W'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  assign limit_hit = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign stall_hit = (STALL_LIMIT != 0) && (stall_nxt == SC_W'(STALL_LIMIT - 1));
  assign trigger   = run && (dump_req || limit_hit || stall_hit);

  always_comb begin
    cause = CAUSE_NONE;
    if (dump_req)       cause = CAUSE_REQ;
    else if (limit_hit) cause = CAUSE_LIMIT;
    else if (stall_hit) cause = CAUSE_STALL;
  end

  // The count freezes on the trigger cycle so it reports the cycle the halt was seen in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_prev   <= '0;
      stall_cnt <= '0;
      cycle_cnt <= '0;
    end else if (run) begin
      pc_prev   <= pc;
      stall_cnt <= stall_nxt;
      if (!trigger && (cycle_cnt != CNT_W'(MAX_CYCLES))) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_dump_unit.sv
// End-of-run monitor: halts the CPU on request, cycle budget or stuck PC, then streams
// every register and data-memory word over valid/ready, registers first.
module cpu_dump_unit
  import cpu_dump_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int PC_W        = 32,
  parameter  int NUM_REGS    = 32,
  parameter  int MEM_WORDS   = 32,
  parameter  int MAX_CYCLES  = 560,
  parameter  int STALL_LIMIT = 4,
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1),
  localparam int IDX_W       = clog2_min1((NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              dump_req_i,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [IDX_W-1:0]  dm_addr_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic              dump_sel_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              halted_o,
  output logic              done_o,
  output logic [1:0]        cause_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(MEM_WORDS - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              in_run;
  logic              trigger;
  logic [1:0]        trig_cause;
  logic              load;
  logic              last_hs;
  logic              vld_nxt, sel_nxt, last_nxt, halt_nxt, done_nxt;
  logic [IDX_W-1:0]  oidx_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [1:0]        cause_nxt;

  assign in_run  = (state == RUN);
  assign load    = !dump_valid_o || dump_ready_i;
  assign last_hs = dump_valid_o && dump_ready_i && dump_last_o;

  assign rf_addr_o = (state == SCAN_RF) ? idx : '0;
  assign dm_addr_o = (state == SCAN_DM) ? idx : '0;

  halt_detector #(
    .PC_W        (PC_W),
    .MAX_CYCLES  (MAX_CYCLES),
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_W       (CNT_W)
  ) u_halt (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .run       (in_run),
    .pc        (pc_i),
    .dump_req  (dump_req_i),
    .trigger   (trigger),
    .cause     (trig_cause),
    .cycle_cnt (cycle_cnt_o)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    vld_nxt   = dump_valid_o;
    sel_nxt   = dump_sel_o;
    oidx_nxt  = dump_idx_o;
    data_nxt  = dump_data_o;
    last_nxt  = dump_last_o;
    halt_nxt  = halted_o;
    cause_nxt = cause_o;
    done_nxt  = done_o;
    case (state)
      RUN: begin
        if (trigger) begin
          state_nxt = SCAN_RF;
          halt_nxt  = 1'b1;
          cause_nxt = trig_cause;
          idx_nxt   = '0;
        end
      end
      SCAN_RF: begin
        if (load) begin
          vld_nxt  = 1'b1;
          sel_nxt  = 1'b0;
          oidx_nxt = idx;
          data_nxt = rf_data_i;
          last_nxt = 1'b0;
          if (idx == RF_LAST) begin
            state_nxt = SCAN_DM;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      SCAN_DM: begin
        // Once the final word sits in the output register, only its acceptance moves on.
        if (last_hs) begin
          state_nxt = DONE;
          vld_nxt   = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (load) begin
          vld_nxt  = 1'b1;
          sel_nxt  = 1'b1;
          oidx_nxt = idx;
          data_nxt = dm_data_i;
          last_nxt = (idx == DM_LAST);
          if (idx != DM_LAST) idx_nxt = idx + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= RUN;
      idx          <= '0;
      dump_valid_o <= 1'b0;
      dump_sel_o   <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
      dump_last_o  <= 1'b0;
      halted_o     <= 1'b0;
      cause_o      <= CAUSE_NONE;
      done_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      dump_valid_o <= vld_nxt;
      dump_sel_o   <= sel_nxt;
      dump_idx_o   <= oidx_nxt;
      dump_data_o  <= data_nxt;
      dump_last_o  <= last_nxt;
      halted_o     <= halt_nxt;
      cause_o      <= cause_nxt;
      done_o       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_dump_unit.sv
// Bench for cpu_dump_unit: halt scenarios checked against a PC-history model, dump streams
// checked against a beat scoreboard under several ready patterns, plus a mid-scan reset.
module tb_cpu_dump_unit;
  import cpu_dump_pkg::*;

  localparam int NR    = 32;
  localparam int MW    = 32;
  localparam int MAXC  = 10;
  localparam int SL    = 4;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = 5;
  localparam int BEATS = NR + MW;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc;
  logic             dump_req;
  logic [IDX_W-1:0] rf_addr, dm_addr;
  logic [31:0]      rf_data, dm_data;
  logic             dump_valid, dump_ready, dump_sel, dump_last;
  logic [IDX_W-1:0] dump_idx;
  logic [31:0]      dump_data;
  logic             halted, done;
  logic [1:0]       cause;
  logic [CNT_W-1:0] cycle_cnt;

  logic [31:0] rf_mem [NR];
  logic [31:0] dm_mem [MW];
  assign rf_data = rf_mem[rf_addr];
  assign dm_data = dm_mem[dm_addr];

  int vectors;
  int miscompares;
  int pc_seq[$];
  bit req_seq[$];

  always #5 clk = ~clk;

  cpu_dump_unit #(
    .DATA_W(32), .PC_W(32), .NUM_REGS(NR), .MEM_WORDS(MW),
    .MAX_CYCLES(MAXC), .STALL_LIMIT(SL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .dump_req_i(dump_req),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .dm_addr_o(dm_addr), .dm_data_i(dm_data),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_sel_o(dump_sel),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data), .dump_last_o(dump_last),
    .halted_o(halted), .done_o(done), .cause_o(cause), .cycle_cnt_o(cycle_cnt)
  );

  // Reference: first cycle whose request, budget or PC history calls for a halt.
  // hist[0] is the reset value of the previous PC; a stall is SL equal PC values in a row.
  function automatic int model_trigger(output logic [1:0] c);
    int hist[$];
    int p;
    bit r;
    bit stuck;
    hist.push_back(0);
    c = CAUSE_NONE;
    for (int t = 0; t < 64; t++) begin
      p = (t < pc_seq.size()) ? pc_seq[t] : pc_seq[pc_seq.size()-1];
      r = (t < req_seq.size()) ? req_seq[t] : 1'b0;
      hist.push_back(p);
      stuck = (hist.size() >= SL);
      for (int k = 1; k < SL; k++) if (stuck && hist[hist.size()-1-k] != p) stuck = 1'b0;
      if (r)             begin c = CAUSE_REQ;   return t; end
      if (t == MAXC - 1) begin c = CAUSE_LIMIT; return t; end
      if (stuck)         begin c = CAUSE_STALL; return t; end
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; pc = '0; dump_req = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Plays pc_seq/req_seq from cycle 0; reports the first cycle halted is seen and final state.
  task automatic apply_run(output int halt_at, output logic [1:0] c_seen,
                           output logic [CNT_W-1:0] cnt_seen);
    halt_at = -1;
    for (int t = 0; t < 20; t++) begin
      if (halted === 1'b1 && halt_at < 0) halt_at = t;
      pc = 32'(pc_seq[(t < pc_seq.size()) ? t : pc_seq.size()-1]);
      dump_req = (t < req_seq.size()) ? req_seq[t] : 1'b0;
      @(negedge clk);
    end
    c_seen = cause;
    cnt_seen = cycle_cnt;
    dump_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({halted, done, dump_valid, dump_sel, dump_last} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {halted, done, dump_valid, dump_sel, dump_last});
    end
    vectors++;
    if ({cause, cycle_cnt} !== '0) begin
      miscompares++; $display("FAIL reset_cause_cnt: got cause %0d cnt %0d want 0 0", cause, cycle_cnt);
    end
    vectors++;
    if ({dump_idx, rf_addr, dm_addr, dump_data} !== '0) begin
      miscompares++; $display("FAIL reset_idx_data: got idx %0d rf %0d dm %0d data %0h want 0", dump_idx, rf_addr, dm_addr, dump_data);
    end
    pc = 32'h4;
    @(negedge clk);
    vectors++;
    if (cycle_cnt !== CNT_W'(1)) begin
      miscompares++; $display("FAIL reset_first_count: got %0d want 1", cycle_cnt);
    end
  endtask

  task automatic test_stall();
    int t_exp, halt_at; logic [1:0] c_exp, c_seen; logic [CNT_W-1:0] cnt_seen;
    pc_seq.delete(); req_seq.delete();
    for (int t = 0; t < 12; t++) pc_seq.push_back((t < 3) ? 4 * t : 12);
    t_exp = model_trigger(c_exp);
    do_reset();
    apply_run(halt_at, c_seen, cnt_seen);
    vectors++;
    if (halt_at !== t_exp + 1) begin miscompares++; $display("FAIL stall_halt_cycle: got %0d want %0d", halt_at, t_exp + 1); end
    vectors++;
    if (c_seen !== c_exp) begin miscompares++; $display("FAIL stall_cause: got %0d want %0d", c_seen, c_exp); end
    vectors++;
    if (cnt_seen !== CNT_W'(t_exp)) begin miscompares++; $display("FAIL stall_cnt: got %0d want %0d", cnt_seen, t_exp); end
  endtask

  task automatic test_limit();
    int t_exp, halt_at; logic [1:0] c_exp, c_seen; logic [CNT_W-1:0] cnt_seen;
    pc_seq.delete(); req_seq.delete();
    for (int t = 0; t < 20; t++) pc_seq.push_back(4 * t + 4);
    t_exp = model_trigger(c_exp);
    do_reset();
    apply_run(halt_at, c_seen, cnt_seen);
    vectors++;
    if (halt_at !== t_exp + 1) begin miscompares++; $display("FAIL limit_halt_cycle: got %0d want %0d", halt_at, t_exp + 1); end
    vectors++;
    if (c_seen !== c_exp) begin miscompares++; $display("FAIL limit_cause: got %0d want %0d", c_seen, c_exp); end
    vectors++;
    if (cnt_seen !== CNT_W'(t_exp)) begin miscompares++; $display("FAIL limit_cnt_frozen: got %0d want %0d", cnt_seen, t_exp); end
  endtask

  task automatic test_simultaneous();
    int t_exp, halt_at; logic [1:0] c_exp, c_seen; logic [CNT_W-1:0] cnt_seen;
    pc_seq.delete(); req_seq.delete();
    for (int t = 0; t < 20; t++) begin
      pc_seq.push_back(4 * t + 4);
      req_seq.push_back(t == MAXC - 1);
    end
    t_exp = model_trigger(c_exp);
    do_reset();
    apply_run(halt_at, c_seen, cnt_seen);
    vectors++;
    if (halt_at !== t_exp + 1) begin miscompares++; $display("FAIL simul_halt_cycle: got %0d want %0d", halt_at, t_exp + 1); end
    vectors++;
    if (c_seen !== c_exp) begin miscompares++; $display("FAIL simul_cause: got %0d want %0d", c_seen, c_exp); end
  endtask

  task automatic test_random_halt();
    int t_exp, halt_at, p; logic [1:0] c_exp, c_seen; logic [CNT_W-1:0] cnt_seen;
    for (int it = 0; it < 24; it++) begin
      pc_seq.delete(); req_seq.delete();
      p = 0;
      for (int t = 0; t < 12; t++) begin
        if ($urandom_range(0, 1) == 1) p = int'($urandom_range(0, 3)) * 4;
        pc_seq.push_back(p);
        req_seq.push_back($urandom_range(0, 15) == 0);
      end
      t_exp = model_trigger(c_exp);
      do_reset();
      apply_run(halt_at, c_seen, cnt_seen);
      vectors++;
      if (halt_at !== t_exp + 1) begin miscompares++; $display("FAIL rand_halt_cycle[%0d]: got %0d want %0d", it, halt_at, t_exp + 1); end
      vectors++;
      if (c_seen !== c_exp) begin miscompares++; $display("FAIL rand_cause[%0d]: got %0d want %0d", it, c_seen, c_exp); end
      vectors++;
      if (cnt_seen !== CNT_W'(t_exp)) begin miscompares++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", it, cnt_seen, t_exp); end
    end
  endtask

  // mode 0: ready high; 1: alternating with a 5-cycle hold at beat 10; 2: random ready.
  task automatic test_stream(input int mode);
    int n, hold, hs_cycle, done_cycle;
    bit rdy, rdy_prev, held10;
    logic [39:0] snap;
    logic exp_sel, exp_last;
    logic [IDX_W-1:0] exp_idx;
    logic [31:0] exp_data;
    for (int k = 0; k < NR; k++) rf_mem[k] = (mode == 2) ? $urandom : 32'(k * 3);
    for (int k = 0; k < MW; k++) dm_mem[k] = (mode == 2) ? $urandom : 32'(100 + k);
    do_reset();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    vectors++;
    if ({halted, cause} !== {1'b1, CAUSE_REQ}) begin
      miscompares++; $display("FAIL stream%0d_halt: got halted %b cause %0d want 1 1", mode, halted, cause);
    end
    vectors++;
    if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL stream%0d_early_valid: got %b want 0", mode, dump_valid); end
    n = 0; hold = 0; hs_cycle = -1; done_cycle = -1; rdy_prev = 1'b1; held10 = 1'b0; snap = '0;
    for (int c = 1; c < 400; c++) begin
      if (done === 1'b1) begin done_cycle = c; break; end
      if (c == 2) begin
        vectors++;
        if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL stream%0d_first_valid: got %b want 1", mode, dump_valid); end
      end
      if (!rdy_prev && snap[39]) begin
        vectors++;
        if ({dump_valid, dump_sel, dump_idx, dump_data, dump_last} !== snap) begin
          miscompares++; $display("FAIL stream%0d_hold: got %h want %h", mode, {dump_valid, dump_sel, dump_idx, dump_data, dump_last}, snap);
        end
      end
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (!held10 && dump_valid && n == 10) begin hold = 5; held10 = 1'b1; end
          if (hold > 0) begin rdy = 1'b0; hold--; end
          else rdy = (c % 2 == 1);
        end
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      if (dump_valid && rdy) begin
        exp_sel  = (n >= NR);
        exp_idx  = IDX_W'(exp_sel ? n - NR : n);
        exp_data = exp_sel ? dm_mem[exp_idx] : rf_mem[exp_idx];
        exp_last = (n == BEATS - 1);
        vectors++;
        if ({dump_sel, dump_idx, dump_data, dump_last} !== {exp_sel, exp_idx, exp_data, exp_last}) begin
          miscompares++;
          $display("FAIL stream%0d_beat%0d: got sel %b idx %0d data %0h last %b want sel %b idx %0d data %0h last %b",
                   mode, n, dump_sel, dump_idx, dump_data, dump_last, exp_sel, exp_idx, exp_data, exp_last);
        end
        vectors++;
        if ((dump_sel ? rf_addr : dm_addr) !== '0) begin
          miscompares++; $display("FAIL stream%0d_idle_addr%0d: got rf %0d dm %0d want idle port 0", mode, n, rf_addr, dm_addr);
        end
        if (n == BEATS - 1) hs_cycle = c;
        n++;
      end
      snap = {dump_valid, dump_sel, dump_idx, dump_data, dump_last};
      rdy_prev = rdy;
      dump_ready = rdy;
      dump_req = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    vectors++;
    if (n !== BEATS) begin miscompares++; $display("FAIL stream%0d_count: got %0d want %0d", mode, n, BEATS); end
    vectors++;
    if (hs_cycle < 0 || done_cycle !== hs_cycle + 1) begin
      miscompares++; $display("FAIL stream%0d_done_cycle: got %0d want %0d", mode, done_cycle, hs_cycle + 1);
    end
    if (mode == 0) begin
      vectors++;
      if (hs_cycle !== 1 + BEATS) begin miscompares++; $display("FAIL stream0_rate: got last at %0d want %0d", hs_cycle, 1 + BEATS); end
    end
    @(negedge clk);
    vectors++;
    if ({done, dump_valid, halted, cause, cycle_cnt} !== {1'b1, 1'b0, 1'b1, CAUSE_REQ, CNT_W'(0)}) begin
      miscompares++; $display("FAIL stream%0d_final: got done %b valid %b halted %b cause %0d cnt %0d want 1 0 1 1 0",
                              mode, done, dump_valid, halted, cause, cycle_cnt);
    end
    dump_req = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, t_exp, halt_at; logic [1:0] c_exp, c_seen; logic [CNT_W-1:0] cnt_seen;
    do_reset();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    dump_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      if (dump_valid === 1'b1) n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 20 || dump_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_reach: got %0d beats valid %b want 20 1", n, dump_valid); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({halted, done, dump_valid, dump_sel, dump_last, cause, cycle_cnt, dump_idx, rf_addr, dm_addr, dump_data} !== '0) begin
      miscompares++; $display("FAIL midrst_zero: got halted %b done %b valid %b cause %0d cnt %0d idx %0d data %0h want all 0",
                              halted, done, dump_valid, cause, cycle_cnt, dump_idx, dump_data);
    end
    dump_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pc_seq.delete(); req_seq.delete();
    for (int t = 0; t < 20; t++) pc_seq.push_back(4 * t + 8);
    t_exp = model_trigger(c_exp);
    apply_run(halt_at, c_seen, cnt_seen);
    vectors++;
    if (halt_at !== t_exp + 1 || c_seen !== c_exp || cnt_seen !== CNT_W'(t_exp)) begin
      miscompares++; $display("FAIL midrst_restart: got halt %0d cause %0d cnt %0d want %0d %0d %0d",
                              halt_at, c_seen, cnt_seen, t_exp + 1, c_exp, t_exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; pc = '0; dump_req = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_stall();
    test_limit();
    test_simultaneous();
    test_random_halt();
    test_stream(0);
    test_stream(1);
    test_stream(2);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
